// File: rtl/multi_alarm_clk.sv
// Alarm clock: BCD HH:MM timekeeping, keypad entry FSM, NUM_ALARMS alarm slots.
// Define SNOOZE_ALARM_EN to build the snooze feature.
module multi_alarm_clk #(
   parameter int NUM_ALARMS  = 4,
   parameter int SEL_W       = 2,
   parameter int CLK_PER_SEC = 256,
   parameter int SNOOZE_MIN  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       key,
   input  logic             key_valid,
   input  logic             time_button,
   input  logic             alarm_button,
   input  logic             snooze,
   input  logic             alarm_stop,
   input  logic             fast_watch,
   input  logic [SEL_W-1:0] alarm_sel,
   output logic [7:0]       ms_hr,
   output logic [7:0]       ls_hr,
   output logic [7:0]       ms_minute,
   output logic [7:0]       ls_minute,
   output logic             alarm_sound,
   output logic [SEL_W-1:0] alarm_id
);

   localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

   typedef enum logic [1:0] {IDLE, ENTRY, SHOW_AL} state_t;

   state_t                       state_q, state_d;
   logic [PW-1:0]                presc_q, presc_d;
   logic [5:0]                   sec_q, sec_d;
   logic [15:0]                  time_q, time_d;
   logic [15:0]                  buf_q, buf_d;
   logic [NUM_ALARMS-1:0][15:0]  alm_q, alm_d;
   logic [NUM_ALARMS-1:0]        alm_en_q, alm_en_d;
   logic [3:0]                   tick_q, tick_d;
   logic                         tb_q, tb_d, ab_q, ab_d;
   logic                         min_upd_q, min_upd_d;
   logic                         sound_q, sound_d;
   logic [SEL_W-1:0]             id_q, id_d;

   logic        tb_edge, ab_edge, key_ok, buf_ok, time_load;
   logic        one_second, one_minute, m_hit;
   logic [SEL_W-1:0] m_id;
   logic [15:0] disp;

`ifdef SNOOZE_ALARM_EN
   localparam int SW = $clog2(SNOOZE_MIN + 1);
   logic          sz_q, sz_d, snz_act_q, snz_act_d;
   logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`else
   logic unused_snooze;
   assign unused_snooze = snooze | (SNOOZE_MIN < 0);
`endif

   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [3:0] h1, h0, m1, m0;
      {h1, h0, m1, m0} = t;
      if (m0 != 4'd9) m0 = m0 + 4'd1;
      else begin
         m0 = 4'd0;
         if (m1 != 4'd5) m1 = m1 + 4'd1;
         else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin h1 = 4'd0; h0 = 4'd0; end
            else if (h0 == 4'd9) begin h0 = 4'd0; h1 = h1 + 4'd1; end
            else h0 = h0 + 4'd1;
         end
      end
      return {h1, h0, m1, m0};
   endfunction

   assign tb_edge    = time_button & ~tb_q;
   assign ab_edge    = alarm_button & ~ab_q;
   assign key_ok     = key_valid && (key <= 4'd9);
   assign buf_ok     = ((buf_q[15:12] < 4'd2) || (buf_q[15:12] == 4'd2 && buf_q[11:8] <= 4'd3))
                       && (buf_q[7:4] <= 4'd5);
   assign time_load  = (state_q == ENTRY) && tb_edge && buf_ok;
   assign one_second = (presc_q == PW'(CLK_PER_SEC - 1));
   assign one_minute = one_second && (fast_watch || sec_q == 6'd59);

   // Lowest enabled slot matching the current time wins.
   always_comb begin
      m_hit = 1'b0;
      m_id  = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alm_en_q[i] && alm_q[i] == time_q) begin
            m_hit = 1'b1;
            m_id  = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      presc_d   = one_second ? '0 : presc_q + PW'(1);
      sec_d     = sec_q;
      time_d    = time_q;
      buf_d     = buf_q;
      alm_d     = alm_q;
      alm_en_d  = alm_en_q;
      tick_d    = tick_q;
      tb_d      = time_button;
      ab_d      = alarm_button;
      min_upd_d = one_minute && !time_load;
      sound_d   = sound_q;
      id_d      = id_q;
`ifdef SNOOZE_ALARM_EN
      sz_d      = snooze;
      snz_act_d = snz_act_q;
      snz_cnt_d = snz_cnt_q;
`endif

      if (one_second) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      if (one_minute) time_d = bcd_inc(time_q);

      case (state_q)
         IDLE: begin
            if (tb_edge) begin
               state_d = IDLE;
            end else if (ab_edge) begin
               state_d = SHOW_AL;
               tick_d  = 4'd0;
            end else if (key_ok) begin
               buf_d   = {12'h000, key};
               state_d = ENTRY;
               tick_d  = 4'd0;
            end
         end
         ENTRY: begin
            if (tb_edge) begin
               state_d = IDLE;
               if (buf_ok) begin
                  time_d  = buf_q;
                  presc_d = '0;
                  sec_d   = 6'd0;
               end
            end else if (ab_edge) begin
               state_d = IDLE;
               for (int i = 0; i < NUM_ALARMS; i++) begin
                  if (buf_ok && alarm_sel == SEL_W'(i)) begin
                     alm_d[i]    = buf_q;
                     alm_en_d[i] = 1'b1;
                  end
               end
            end else if (key_ok) begin
               buf_d  = {buf_q[11:0], key};
               tick_d = 4'd0;
            end else if (one_second) begin
               if (tick_q == 4'd9) state_d = IDLE;
               else tick_d = tick_q + 4'd1;
            end
         end
         SHOW_AL: begin
            if (tb_edge) begin
               for (int i = 0; i < NUM_ALARMS; i++)
                  if (alarm_sel == SEL_W'(i)) alm_en_d[i] = ~alm_en_q[i];
            end else if (ab_edge) begin
               state_d = IDLE;
            end else if (one_second) begin
               if (tick_q == 4'd4) state_d = IDLE;
               else tick_d = tick_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (min_upd_q && m_hit) begin
         sound_d = 1'b1;
         id_d    = m_id;
      end
`ifdef SNOOZE_ALARM_EN
      if (snooze && !sz_q && sound_q) begin
         sound_d   = 1'b0;
         snz_act_d = 1'b1;
         snz_cnt_d = SW'(SNOOZE_MIN);
      end else if (snz_act_q && one_minute) begin
         if (snz_cnt_q <= SW'(1)) begin
            sound_d   = 1'b1;
            snz_act_d = 1'b0;
            snz_cnt_d = '0;
         end else begin
            snz_cnt_d = snz_cnt_q - SW'(1);
         end
      end
`endif
      // Stop and a real time load silence everything, including pending snooze.
      if (alarm_stop || time_load) begin
         sound_d = 1'b0;
`ifdef SNOOZE_ALARM_EN
         snz_act_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         sec_q     <= '0;
         time_q    <= '0;
         buf_q     <= '0;
         alm_q     <= '0;
         alm_en_q  <= '0;
         tick_q    <= '0;
         tb_q      <= 1'b0;
         ab_q      <= 1'b0;
         min_upd_q <= 1'b0;
         sound_q   <= 1'b0;
         id_q      <= '0;
`ifdef SNOOZE_ALARM_EN
         sz_q      <= 1'b0;
         snz_act_q <= 1'b0;
         snz_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         sec_q     <= sec_d;
         time_q    <= time_d;
         buf_q     <= buf_d;
         alm_q     <= alm_d;
         alm_en_q  <= alm_en_d;
         tick_q    <= tick_d;
         tb_q      <= tb_d;
         ab_q      <= ab_d;
         min_upd_q <= min_upd_d;
         sound_q   <= sound_d;
         id_q      <= id_d;
`ifdef SNOOZE_ALARM_EN
         sz_q      <= sz_d;
         snz_act_q <= snz_act_d;
         snz_cnt_q <= snz_cnt_d;
`endif
      end
   end

   always_comb begin
      disp = time_q;
      case (state_q)
         ENTRY:   disp = buf_q;
         SHOW_AL: begin
            disp = 16'h0000;
            for (int i = 0; i < NUM_ALARMS; i++)
               if (alarm_sel == SEL_W'(i)) disp = alm_q[i];
         end
         default: disp = time_q;
      endcase
   end

   assign ms_hr       = 8'h30 + {4'h0, disp[15:12]};
   assign ls_hr       = 8'h30 + {4'h0, disp[11:8]};
   assign ms_minute   = 8'h30 + {4'h0, disp[7:4]};
   assign ls_minute   = 8'h30 + {4'h0, disp[3:0]};
   assign alarm_sound = sound_q;
   assign alarm_id    = id_q;

endmodule
